// File: rtl/snake_tile_renderer.sv
// Snake overlay renderer: builds a double-buffered tile bitmap from the segment
// list once per frame and composites snake/food colours over the background.
module snake_tile_renderer #(
   parameter int          MAX_SEGS   = 100,
   parameter int          COORD_W    = 32,
   parameter int          COLS       = 10,
   parameter int          ROWS       = 10,
   parameter int          TILE       = 40,
   parameter int          BOARD_X0   = 48,
   parameter int          BOARD_Y0   = 48,
   parameter logic [11:0] HEAD_COLOR = 12'h0F0,
   parameter logic [11:0] BODY_COLOR = 12'h080,
   parameter logic [11:0] FOOD_COLOR = 12'hF00,
   parameter logic [11:0] OVER_COLOR = 12'h888
) (
   input  logic                              clk25,
   input  logic                              reset,
   input  logic                              frame_start,
   input  logic                              active,
   input  logic [9:0]                        x,
   input  logic [9:0]                        y,
   input  logic [11:0]                       bg_color,
   input  logic [MAX_SEGS*COORD_W-1:0]       seg_x,
   input  logic [MAX_SEGS*COORD_W-1:0]       seg_y,
   input  logic [COORD_W-1:0]                food_x,
   input  logic [COORD_W-1:0]                food_y,
   input  logic                              game_done,
   output logic [11:0]                       color_out,
   output logic                              build_busy,
   output logic [$clog2(MAX_SEGS+1)-1:0]     seg_count,
   output logic                              overflow
);
   localparam int CNT_W = $clog2(MAX_SEGS+1);
   localparam int NT    = COLS*ROWS;
   localparam int IDX_W = (NT > 1) ? $clog2(NT) : 1;
   localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;

   localparam logic [9:0]         X_LO     = 10'(BOARD_X0);
   localparam logic [9:0]         X_HI     = 10'(BOARD_X0 + COLS*TILE);
   localparam logic [9:0]         Y_LO     = 10'(BOARD_Y0);
   localparam logic [9:0]         Y_HI     = 10'(BOARD_Y0 + ROWS*TILE);
   localparam logic [9:0]         TILE_PX  = 10'(TILE);
   localparam logic [COORD_W-1:0] COLS_C   = COORD_W'(COLS);
   localparam logic [COORD_W-1:0] ROWS_C   = COORD_W'(ROWS);
   localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(MAX_SEGS-1);

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_BUILD, S_SWAP} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   idx_q;
   logic               front_q;
   logic               back;

   logic [NT-1:0]      map_q        [2];
   logic [CW-1:0]      head_col_q   [2];
   logic [RW-1:0]      head_row_q   [2];
   logic               head_valid_q [2];
   logic [CNT_W-1:0]   cnt_q        [2];
   logic               ovf_q        [2];

   logic [COORD_W-1:0] cur_x, cur_y;
   logic               seg_term, seg_in_range, last_seg;
   logic [IDX_W-1:0]   seg_bit;

   assign back         = ~front_q;
   assign cur_x        = seg_x[COORD_W*idx_q +: COORD_W];
   assign cur_y        = seg_y[COORD_W*idx_q +: COORD_W];
   assign seg_term     = (&cur_x) | (&cur_y);
   assign seg_in_range = (cur_x < COLS_C) && (cur_y < ROWS_C);
   assign seg_bit      = IDX_W'(cur_y) * IDX_W'(COLS) + IDX_W'(cur_x);
   assign last_seg     = (idx_q == LAST_IDX);

   always_ff @(posedge clk25 or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // frame_start outside IDLE is dropped, never queued.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (frame_start) state_d = S_CLEAR;
         S_CLEAR: state_d = S_BUILD;
         S_BUILD: if (seg_term || last_seg) state_d = S_SWAP;
         S_SWAP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk25 or negedge reset) begin
      if (!reset) begin
         front_q <= 1'b0;
         idx_q   <= '0;
         for (int b = 0; b < 2; b++) begin
            map_q[b]        <= '0;
            head_col_q[b]   <= '0;
            head_row_q[b]   <= '0;
            head_valid_q[b] <= 1'b0;
            cnt_q[b]        <= '0;
            ovf_q[b]        <= 1'b0;
         end
      end else begin
         case (state_q)
            S_CLEAR: begin
               map_q[back]        <= '0;
               head_valid_q[back] <= 1'b0;
               cnt_q[back]        <= '0;
               ovf_q[back]        <= 1'b0;
               idx_q              <= '0;
            end
            S_BUILD: begin
               if (!seg_term) begin
                  // Out-of-range segments are skipped but still counted.
                  if (seg_in_range) begin
                     map_q[back][seg_bit] <= 1'b1;
                     if (idx_q == '0) begin
                        head_col_q[back]   <= CW'(cur_x);
                        head_row_q[back]   <= RW'(cur_y);
                        head_valid_q[back] <= 1'b1;
                     end
                  end else begin
                     ovf_q[back] <= 1'b1;
                  end
                  cnt_q[back] <= idx_q + 1'b1;
                  idx_q       <= idx_q + 1'b1;
               end
            end
            S_SWAP:  front_q <= ~front_q;
            default: ;
         endcase
      end
   end

   logic [9:0]       dx, dy;
   logic             inb_d;
   logic             act1_q, inb1_q;
   logic [CW-1:0]    col1_q;
   logic [RW-1:0]    row1_q;
   logic [11:0]      bg1_q;
   logic [IDX_W-1:0] pix_bit;
   logic             is_head, is_body, is_food;
   logic [11:0]      color_d, color_q;

   assign dx    = x - X_LO;
   assign dy    = y - Y_LO;
   assign inb_d = (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);

   always_ff @(posedge clk25 or negedge reset) begin
      if (!reset) begin
         act1_q  <= 1'b0;
         inb1_q  <= 1'b0;
         col1_q  <= '0;
         row1_q  <= '0;
         bg1_q   <= '0;
         color_q <= '0;
      end else begin
         act1_q  <= active;
         inb1_q  <= inb_d;
         col1_q  <= CW'(dx / TILE_PX);
         row1_q  <= RW'(dy / TILE_PX);
         bg1_q   <= bg_color;
         color_q <= color_d;
      end
   end

   // Food and game_done are taken live in stage 2, not buffered.
   assign pix_bit = IDX_W'(row1_q) * IDX_W'(COLS) + IDX_W'(col1_q);
   assign is_head = head_valid_q[front_q] && (head_col_q[front_q] == col1_q) &&
                    (head_row_q[front_q] == row1_q);
   assign is_body = map_q[front_q][pix_bit];
   assign is_food = ~(&food_x) && ~(&food_y) &&
                    (food_x == COORD_W'(col1_q)) && (food_y == COORD_W'(row1_q));

   always_comb begin
      color_d = bg1_q;
      if (!act1_q)      color_d = 12'h000;
      else if (!inb1_q) color_d = bg1_q;
      else if (is_head) color_d = game_done ? OVER_COLOR : HEAD_COLOR;
      else if (is_body) color_d = game_done ? OVER_COLOR : BODY_COLOR;
      else if (is_food) color_d = FOOD_COLOR;
   end

   assign color_out  = color_q;
   assign build_busy = (state_q != S_IDLE);
   assign seg_count  = cnt_q[front_q];
   assign overflow   = ovf_q[front_q];

endmodule

// File: tb/tb_snake_tile_renderer.sv
// Directed bench for snake_tile_renderer with default parameters and
// hand-computed pixel colours, build lengths and front-buffer status.
module tb_snake_tile_renderer;
   localparam int          MAX_SEGS = 100;
   localparam int          COORD_W  = 32;
   localparam logic [11:0] HEAD     = 12'h0F0;
   localparam logic [11:0] BODY     = 12'h080;
   localparam logic [11:0] FOOD     = 12'hF00;
   localparam logic [11:0] OVER     = 12'h888;
   localparam logic [11:0] BG       = 12'h3A5;

   logic                         clk25;
   logic                         reset;
   logic                         frame_start;
   logic                         active;
   logic [9:0]                   x, y;
   logic [11:0]                  bg_color;
   logic [MAX_SEGS*COORD_W-1:0]  seg_x, seg_y;
   logic [COORD_W-1:0]           food_x, food_y;
   logic                         game_done;
   logic [11:0]                  color_out;
   logic                         build_busy;
   logic [6:0]                   seg_count;
   logic                         overflow;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   snake_tile_renderer dut (
      .clk25(clk25), .reset(reset), .frame_start(frame_start), .active(active),
      .x(x), .y(y), .bg_color(bg_color), .seg_x(seg_x), .seg_y(seg_y),
      .food_x(food_x), .food_y(food_y), .game_done(game_done),
      .color_out(color_out), .build_busy(build_busy), .seg_count(seg_count),
      .overflow(overflow)
   );

   initial clk25 = 1'b0;
   always #20 clk25 = ~clk25;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_list();
      seg_x = '1;
      seg_y = '1;
   endtask

   task automatic set_seg(input int i, input int cx, input int cy);
      seg_x[COORD_W*i +: COORD_W] = cx;
      seg_y[COORD_W*i +: COORD_W] = cy;
   endtask

   // Pulses frame_start and counts the cycles build_busy stays high.
   task automatic run_frame(output int cycles);
      @(negedge clk25);
      frame_start = 1'b1;
      @(posedge clk25); #1;
      frame_start = 1'b0;
      cycles = 0;
      while (build_busy && cycles < 400) begin
         cycles++;
         @(posedge clk25); #1;
      end
   endtask

   task automatic pix_chk(input string tag, input int px, input int py, input logic [11:0] exp);
      @(negedge clk25);
      x      = px[9:0];
      y      = py[9:0];
      active = 1'b1;
      @(posedge clk25);
      @(posedge clk25); #1;
      chk(tag, color_out, exp);
   endtask

   int cyc;
   int k;

   initial begin
      reset = 1'b0; frame_start = 1'b0; active = 1'b0; x = '0; y = '0;
      bg_color = BG; food_x = '1; food_y = '1; game_done = 1'b0;
      clear_list();

      // Reset state
      repeat (3) @(posedge clk25);
      #1;
      chk("rst_color", color_out, 12'h000);
      chk("rst_busy", build_busy, 1'b0);
      chk("rst_count", seg_count, 7'd0);
      chk("rst_ovf", overflow, 1'b0);
      @(negedge clk25);
      reset = 1'b1;

      // Basic build: head (2,3), body (1,3),(0,3), terminator at 3
      clear_list();
      set_seg(0, 2, 3); set_seg(1, 1, 3); set_seg(2, 0, 3);
      run_frame(cyc);
      chk("basic_busy_cycles", cyc, 6);
      chk("basic_count", seg_count, 7'd3);
      chk("basic_ovf", overflow, 1'b0);
      pix_chk("basic_head", 128, 168, HEAD);
      pix_chk("basic_body", 88, 168, BODY);
      pix_chk("basic_body_col0", 48, 168, BODY);
      pix_chk("basic_empty", 208, 168, BG);
      @(negedge clk25); x = 10'd128; y = 10'd168; active = 1'b0;
      @(posedge clk25); @(posedge clk25); #1;
      chk("basic_inactive", color_out, 12'h000);

      // Two-cycle latency: one head pixel in a stream of off-board pixels
      @(negedge clk25); x = 10'd0; y = 10'd0; active = 1'b1;
      repeat (3) @(posedge clk25);
      @(negedge clk25); x = 10'd128; y = 10'd168;
      @(posedge clk25); #1;
      chk("lat_edge1", color_out, BG);
      @(negedge clk25); x = 10'd0; y = 10'd0;
      @(posedge clk25); #1;
      chk("lat_edge2", color_out, HEAD);
      @(posedge clk25); #1;
      chk("lat_edge3", color_out, BG);

      // Tile boundaries, head alone at (0,0)
      clear_list();
      set_seg(0, 0, 0);
      run_frame(cyc);
      chk("bnd_busy_cycles", cyc, 4);
      chk("bnd_count", seg_count, 7'd1);
      pix_chk("bnd_x47", 47, 48, BG);
      pix_chk("bnd_x48", 48, 48, HEAD);
      pix_chk("bnd_x87", 87, 48, HEAD);
      pix_chk("bnd_x88", 88, 48, BG);
      pix_chk("bnd_y47", 48, 47, BG);
      pix_chk("bnd_y87", 48, 87, HEAD);
      pix_chk("bnd_y88", 48, 88, BG);

      // Priority and game-over: head (5,5), body (6,5)
      clear_list();
      set_seg(0, 5, 5); set_seg(1, 6, 5);
      food_x = 6; food_y = 5;
      run_frame(cyc);
      chk("pri_count", seg_count, 7'd2);
      pix_chk("pri_food_under_body", 288, 248, BODY);
      pix_chk("pri_head", 248, 248, HEAD);
      game_done = 1'b1;
      pix_chk("pri_over_body", 288, 248, OVER);
      pix_chk("pri_over_head", 248, 248, OVER);
      food_x = 8; food_y = 8;
      pix_chk("pri_food_only_over", 368, 368, FOOD);
      game_done = 1'b0;
      pix_chk("pri_head_after_over", 248, 248, HEAD);
      food_x = 9; food_y = 9;
      pix_chk("pri_food_last_px", 447, 447, FOOD);
      pix_chk("pri_past_board", 448, 447, BG);
      food_x = '1; food_y = '1;

      // Full list, no terminator, index 5 off the board
      clear_list();
      for (int i = 0; i < MAX_SEGS; i++) set_seg(i, i % 10, i / 10);
      set_seg(5, 12, 0);
      run_frame(cyc);
      chk("full_busy_cycles", cyc, 102);
      chk("full_count", seg_count, 7'd100);
      chk("full_ovf", overflow, 1'b1);
      pix_chk("full_head", 48, 48, HEAD);
      pix_chk("full_skipped_tile", 248, 48, BG);
      pix_chk("full_body", 288, 48, BODY);
      pix_chk("full_last_seg", 447, 447, BODY);

      // Double buffering: 30 duplicate segments at (3,3), second pulse mid-build
      clear_list();
      for (int i = 0; i < 30; i++) set_seg(i, 3, 3);
      @(negedge clk25); x = 10'd288; y = 10'd48; active = 1'b1;
      repeat (3) @(posedge clk25);
      @(negedge clk25);
      frame_start = 1'b1;
      @(posedge clk25); #1;
      frame_start = 1'b0;
      cyc = 0;
      k = 0;
      while (build_busy && k < 400) begin
         cyc++;
         if (k == 10) begin
            chk("db_old_color_mid_build", color_out, BODY);
            chk("db_old_count_mid_build", seg_count, 7'd100);
         end
         frame_start = (k == 5);
         @(posedge clk25); #1;
         k++;
      end
      frame_start = 1'b0;
      chk("db_busy_cycles", cyc, 33);
      chk("db_color_swap_plus1", color_out, BODY);
      @(posedge clk25); #1;
      chk("db_color_swap_plus2", color_out, BG);
      chk("db_count", seg_count, 7'd30);
      chk("db_ovf", overflow, 1'b0);
      pix_chk("db_new_head", 168, 168, HEAD);

      // Reset in the middle of a 100-segment build
      clear_list();
      for (int i = 0; i < MAX_SEGS; i++) set_seg(i, i % 10, i / 10);
      @(negedge clk25);
      frame_start = 1'b1;
      @(posedge clk25); #1;
      frame_start = 1'b0;
      repeat (19) @(posedge clk25);
      #1;
      chk("mid_busy_before_reset", build_busy, 1'b1);
      reset = 1'b0;
      #2;
      chk("mid_rst_color", color_out, 12'h000);
      chk("mid_rst_count", seg_count, 7'd0);
      chk("mid_rst_busy", build_busy, 1'b0);
      chk("mid_rst_ovf", overflow, 1'b0);
      @(negedge clk25);
      reset = 1'b1;
      pix_chk("mid_old_head_gone", 168, 168, BG);
      pix_chk("mid_no_snake", 48, 48, BG);
      chk("mid_idle_after", build_busy, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
